// File: rtl/icache_dm.sv
// Read-only direct-mapped instruction cache: 256 sets of 16-byte lines held in registers,
// single outstanding line refill, with a one-cycle hit path from the LOOKUP stage.
`timescale 1ns/1ps

module icache_dm (
   input  logic        clk,
   input  logic        resetn,
   input  logic        valid,
   input  logic        op,
   input  logic [7:0]  index,
   input  logic [19:0] tag,
   input  logic [3:0]  offset,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata,
   output logic        rd_req,
   output logic [31:0] rd_addr,
   input  logic        rd_rdy,
   input  logic        ret_valid,
   input  logic        ret_last,
   input  logic [31:0] ret_data
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOOKUP = 2'd1,
      S_MISS   = 2'd2,
      S_REFILL = 2'd3
   } state_t;

   state_t      state_r;
   state_t      state_next_s;

   logic [7:0]  index_buf_r;
   logic [19:0] tag_buf_r;
   logic [3:0]  offset_buf_r;
   logic [1:0]  beat_cnt_r;

   logic [255:0] valid_bits_r;
   logic [19:0]  tag_arr_r  [256];
   logic [31:0]  data_arr_r [256][4];

   logic        hit_s;
   logic        handshake_s;
   logic        refill_wr_s;
   logic        refill_done_s;
   logic [1:0]  word_sel_s;
   logic [31:0] line_word_s;
   logic        unused_s;

   // op is meaningless for a read-only cache; byte offset within a word is not needed either
   assign unused_s      = ^{op, offset_buf_r[1:0]};

   assign word_sel_s    = offset_buf_r[3:2];
   assign line_word_s   = data_arr_r[index_buf_r][word_sel_s];
   assign hit_s         = (state_r == S_LOOKUP) && valid_bits_r[index_buf_r]
                          && (tag_arr_r[index_buf_r] == tag_buf_r);
   assign handshake_s   = valid && addr_ok;
   assign refill_wr_s   = (state_r == S_REFILL) && ret_valid;
   assign refill_done_s = refill_wr_s && ret_last;

   // FSM state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (handshake_s) state_next_s = S_LOOKUP;
            else             state_next_s = S_IDLE;
         end
         S_LOOKUP: begin
            if (!hit_s)           state_next_s = S_MISS;
            else if (handshake_s) state_next_s = S_LOOKUP;
            else                  state_next_s = S_IDLE;
         end
         S_MISS: begin
            if (rd_rdy) state_next_s = S_REFILL;
            else        state_next_s = S_MISS;
         end
         S_REFILL: begin
            if (refill_done_s) state_next_s = S_IDLE;
            else               state_next_s = S_REFILL;
         end
         default: state_next_s = S_IDLE;
      endcase
   end

   // FSM outputs; resetn gates addr_ok so nothing is offered while reset is held
   always_comb begin
      addr_ok = 1'b0;
      data_ok = 1'b0;
      rdata   = 32'h0000_0000;
      rd_req  = 1'b0;
      rd_addr = 32'h0000_0000;
      case (state_r)
         S_IDLE: begin
            addr_ok = valid && resetn;
         end
         S_LOOKUP: begin
            if (hit_s) begin
               addr_ok = valid && resetn;
               data_ok = 1'b1;
               rdata   = line_word_s;
            end else begin
               addr_ok = 1'b0;
               data_ok = 1'b0;
            end
         end
         S_MISS: begin
            rd_req  = 1'b1;
            rd_addr = {tag_buf_r, index_buf_r, 4'b0000};
         end
         S_REFILL: begin
            if (refill_done_s) begin
               data_ok = 1'b1;
               rdata   = (word_sel_s == beat_cnt_r) ? ret_data : line_word_s;
            end else begin
               data_ok = 1'b0;
            end
         end
         default: begin
            addr_ok = 1'b0;
         end
      endcase
   end

   // Request buffer, beat counter and per-set valid bits
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         index_buf_r  <= 8'd0;
         tag_buf_r    <= 20'd0;
         offset_buf_r <= 4'd0;
         beat_cnt_r   <= 2'd0;
         valid_bits_r <= 256'd0;
      end else begin
         if (handshake_s) begin
            index_buf_r  <= index;
            tag_buf_r    <= tag;
            offset_buf_r <= offset;
         end
         if ((state_r == S_MISS) && rd_rdy) begin
            beat_cnt_r <= 2'd0;
         end else if (refill_wr_s) begin
            beat_cnt_r <= beat_cnt_r + 2'd1;
         end
         if (refill_done_s) begin
            valid_bits_r[index_buf_r] <= 1'b1;
         end
      end
   end

   // Tag and data storage; contents are qualified by valid_bits_r so no reset is required
   always_ff @(posedge clk) begin
      if (refill_wr_s) begin
         data_arr_r[index_buf_r][beat_cnt_r] <= ret_data;
      end
      if (refill_done_s) begin
         tag_arr_r[index_buf_r] <= tag_buf_r;
      end
   end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: cold miss, hits, streaming hits, conflict, stalled memory,
// early ret_last, stray beats and reset in the middle of a refill.
`timescale 1ns/1ps

module tb_icache_dm;

   logic        clk = 1'b0;
   logic        resetn;
   logic        valid;
   logic        op;
   logic [7:0]  index;
   logic [19:0] tag;
   logic [3:0]  offset;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;
   logic        rd_req;
   logic [31:0] rd_addr;
   logic        rd_rdy;
   logic        ret_valid;
   logic        ret_last;
   logic [31:0] ret_data;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   icache_dm dut (
      .clk       (clk),
      .resetn    (resetn),
      .valid     (valid),
      .op        (op),
      .index     (index),
      .tag       (tag),
      .offset    (offset),
      .addr_ok   (addr_ok),
      .data_ok   (data_ok),
      .rdata     (rdata),
      .rd_req    (rd_req),
      .rd_addr   (rd_addr),
      .rd_rdy    (rd_rdy),
      .ret_valid (ret_valid),
      .ret_last  (ret_last),
      .ret_data  (ret_data)
   );

   task automatic check(input string name, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      assert (observed === expected) else begin
         failed++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", name, observed, expected);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic v, input logic [19:0] t, input logic [7:0] i, input logic [3:0] o);
      valid  = v;
      tag    = t;
      index  = i;
      offset = o;
   endtask

   task automatic mem(input logic rdy, input logic rv, input logic rl, input logic [31:0] d);
      rd_rdy    = rdy;
      ret_valid = rv;
      ret_last  = rl;
      ret_data  = d;
   endtask

   initial begin
      op = 1'b0;
      resetn = 1'b0;
      req(1'b1, 20'hBFC00, 8'h00, 4'h0);
      mem(1'b0, 1'b0, 1'b0, 32'h0);
      #2;
      check("reset_addr_ok", {31'd0, addr_ok}, 32'd0);
      check("reset_data_ok", {31'd0, data_ok}, 32'd0);
      check("reset_rdata",   rdata, 32'h0);
      check("reset_rd_req",  {31'd0, rd_req}, 32'd0);
      check("reset_rd_addr", rd_addr, 32'h0);
      valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      next_cycle();

      // cold miss on set 0
      req(1'b1, 20'hBFC00, 8'h00, 4'h0); #2;
      check("cold_addr_ok", {31'd0, addr_ok}, 32'd1);
      next_cycle();
      req(1'b0, 20'hBFC00, 8'h00, 4'h0); #2;
      check("cold_lookup_data_ok", {31'd0, data_ok}, 32'd0);
      next_cycle();
      mem(1'b1, 1'b0, 1'b0, 32'h0); #2;
      check("cold_rd_req",  {31'd0, rd_req}, 32'd1);
      check("cold_rd_addr", rd_addr, 32'hBFC0_0000);
      next_cycle();
      mem(1'b0, 1'b1, 1'b0, 32'h11); #2;
      check("cold_refill_rd_req",  {31'd0, rd_req}, 32'd0);
      check("cold_beat0_data_ok",  {31'd0, data_ok}, 32'd0);
      next_cycle();
      mem(1'b0, 1'b1, 1'b0, 32'h22); next_cycle();
      mem(1'b0, 1'b1, 1'b0, 32'h33); next_cycle();
      mem(1'b0, 1'b1, 1'b1, 32'h44); #2;
      check("cold_last_data_ok", {31'd0, data_ok}, 32'd1);
      check("cold_last_rdata",   rdata, 32'h11);
      next_cycle();
      mem(1'b0, 1'b0, 1'b0, 32'h0);

      // single hit, offset 8
      req(1'b1, 20'hBFC00, 8'h00, 4'h8); #2;
      check("hit_addr_ok", {31'd0, addr_ok}, 32'd1);
      next_cycle();
      req(1'b0, 20'hBFC00, 8'h00, 4'h8); #2;
      check("hit_data_ok", {31'd0, data_ok}, 32'd1);
      check("hit_rdata",   rdata, 32'h33);
      check("hit_rd_req",  {31'd0, rd_req}, 32'd0);
      next_cycle(); #2;
      check("idle_data_ok", {31'd0, data_ok}, 32'd0);
      check("idle_rdata",   rdata, 32'h0);

      // back-to-back hits
      req(1'b1, 20'hBFC00, 8'h00, 4'h0); #2;
      check("b2b_addr_ok0", {31'd0, addr_ok}, 32'd1);
      next_cycle();
      req(1'b1, 20'hBFC00, 8'h00, 4'h4); #2;
      check("b2b_addr_ok1", {31'd0, addr_ok}, 32'd1);
      check("b2b_rdata0",   rdata, 32'h11);
      next_cycle();
      req(1'b1, 20'hBFC00, 8'h00, 4'hC); #2;
      check("b2b_addr_ok2", {31'd0, addr_ok}, 32'd1);
      check("b2b_rdata1",   rdata, 32'h22);
      next_cycle();
      req(1'b0, 20'hBFC00, 8'h00, 4'hC); #2;
      check("b2b_data_ok2", {31'd0, data_ok}, 32'd1);
      check("b2b_rdata2",   rdata, 32'h44);
      next_cycle();

      // stray beat while idle must be ignored
      mem(1'b0, 1'b1, 1'b1, 32'hFF); #2;
      check("stray_idle_data_ok", {31'd0, data_ok}, 32'd0);
      next_cycle();
      mem(1'b0, 1'b0, 1'b0, 32'h0);
      req(1'b1, 20'hBFC00, 8'h00, 4'h0); next_cycle();
      req(1'b0, 20'hBFC00, 8'h00, 4'h0); #2;
      check("stray_no_write", rdata, 32'h11);
      next_cycle();

      // conflict miss with a stalled memory, then an early ret_last
      req(1'b1, 20'h00001, 8'h00, 4'h4); #2;
      check("conf_addr_ok", {31'd0, addr_ok}, 32'd1);
      next_cycle();
      req(1'b0, 20'h00001, 8'h00, 4'h4); #2;
      check("conf_lookup_data_ok", {31'd0, data_ok}, 32'd0);
      next_cycle();
      req(1'b1, 20'h00001, 8'h00, 4'hC);
      for (int i = 0; i < 5; i++) begin
         #2;
         check("stall_rd_req",  {31'd0, rd_req}, 32'd1);
         check("stall_rd_addr", rd_addr, 32'h0000_1000);
         check("stall_addr_ok", {31'd0, addr_ok}, 32'd0);
         next_cycle();
      end
      mem(1'b1, 1'b0, 1'b0, 32'h0); #2;
      check("conf_rd_req", {31'd0, rd_req}, 32'd1);
      next_cycle();
      mem(1'b0, 1'b1, 1'b0, 32'hA0); #2;
      check("refill_addr_ok", {31'd0, addr_ok}, 32'd0);
      next_cycle();
      mem(1'b0, 1'b1, 1'b1, 32'hA1); #2;
      check("early_last_data_ok", {31'd0, data_ok}, 32'd1);
      check("early_last_bypass",  rdata, 32'hA1);
      next_cycle();
      mem(1'b0, 1'b0, 1'b0, 32'h0); #2;
      check("held_req_accepted", {31'd0, addr_ok}, 32'd1);
      next_cycle();
      req(1'b1, 20'h00001, 8'h00, 4'h6); #2;
      check("stale_word3", rdata, 32'h44);
      check("stale_hit_addr_ok", {31'd0, addr_ok}, 32'd1);
      next_cycle();
      req(1'b0, 20'h00001, 8'h00, 4'h6); #2;
      check("misaligned_word1", rdata, 32'hA1);
      next_cycle();

      // original tag now misses; reset after two beats of its refill
      req(1'b1, 20'hBFC00, 8'h00, 4'h0); next_cycle();
      req(1'b0, 20'hBFC00, 8'h00, 4'h0); #2;
      check("evicted_miss", {31'd0, data_ok}, 32'd0);
      next_cycle();
      mem(1'b1, 1'b0, 1'b0, 32'h0); #2;
      check("evicted_rd_addr", rd_addr, 32'hBFC0_0000);
      next_cycle();
      mem(1'b0, 1'b1, 1'b0, 32'h55); next_cycle();
      mem(1'b0, 1'b1, 1'b0, 32'h66); next_cycle();
      mem(1'b0, 1'b1, 1'b1, 32'h77);
      req(1'b1, 20'hBFC00, 8'h00, 4'h0);
      resetn = 1'b0; #1;
      check("midrst_addr_ok", {31'd0, addr_ok}, 32'd0);
      check("midrst_data_ok", {31'd0, data_ok}, 32'd0);
      check("midrst_rdata",   rdata, 32'h0);
      check("midrst_rd_req",  {31'd0, rd_req}, 32'd0);
      check("midrst_rd_addr", rd_addr, 32'h0);
      next_cycle();
      req(1'b0, 20'hBFC00, 8'h00, 4'h0);
      mem(1'b0, 1'b1, 1'b1, 32'h88);
      @(negedge clk);
      resetn = 1'b1;
      next_cycle(); #2;
      check("post_rst_stray_data_ok", {31'd0, data_ok}, 32'd0);
      next_cycle();
      mem(1'b0, 1'b0, 1'b0, 32'h0);

      // first access after reset misses and gets a full refill
      req(1'b1, 20'hBFC00, 8'h00, 4'h4); #2;
      check("post_rst_addr_ok", {31'd0, addr_ok}, 32'd1);
      next_cycle();
      req(1'b0, 20'hBFC00, 8'h00, 4'h4); #2;
      check("post_rst_miss", {31'd0, data_ok}, 32'd0);
      next_cycle();
      mem(1'b1, 1'b0, 1'b0, 32'h0); #2;
      check("post_rst_rd_req",  {31'd0, rd_req}, 32'd1);
      check("post_rst_rd_addr", rd_addr, 32'hBFC0_0000);
      next_cycle();
      mem(1'b0, 1'b1, 1'b0, 32'h71); next_cycle();
      mem(1'b0, 1'b1, 1'b0, 32'h72); next_cycle();
      mem(1'b0, 1'b1, 1'b0, 32'h73); next_cycle();
      mem(1'b0, 1'b1, 1'b1, 32'h74); #2;
      check("post_rst_last_data_ok", {31'd0, data_ok}, 32'd1);
      check("post_rst_last_rdata",   rdata, 32'h72);
      next_cycle();
      mem(1'b0, 1'b0, 1'b0, 32'h0);
      req(1'b1, 20'hBFC00, 8'h00, 4'hC); next_cycle();
      req(1'b0, 20'hBFC00, 8'h00, 4'hC); #2;
      check("post_rst_hit_word3", rdata, 32'h74);
      next_cycle();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
